ram_dp_bytemask_init: RTL and testbench

//  True dual-port synchronous RAM with per-lane write masks, selectable read latency and a

---
 rtl/ram_dp_bytemask_init_if.sv | 46 ++++
 rtl/ram_dp_bytemask_init.sv | 174 +++++++++++++++++
 tb/tb_ram_dp_bytemask_init.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_bytemask_init_if.sv
// Bus bundle for ram_dp_bytemask_init: global enable/clear, ready,
// and two symmetric read/write ports (A, B) with lane masks.
interface ram_dp_bytemask_init_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANE_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int NL         = DATA_WIDTH / LANE_WIDTH;
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  cen;
   logic                  clr;
   logic                  ready;

   logic                  wen_a;
   logic [NL-1:0]         lmask_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] din_a;
   logic [DATA_WIDTH-1:0] dout_a;
   logic                  rvalid_a;

   logic                  wen_b;
   logic [NL-1:0]         lmask_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] din_b;
   logic [DATA_WIDTH-1:0] dout_b;
   logic                  rvalid_b;

   modport master (
      output cen, clr,
      output wen_a, lmask_a, addr_a, din_a,
      output wen_b, lmask_b, addr_b, din_b,
      input  ready,
      input  dout_a, rvalid_a,
      input  dout_b, rvalid_b
   );

   modport slave (
      input  cen, clr,
      input  wen_a, lmask_a, addr_a, din_a,
      input  wen_b, lmask_b, addr_b, din_b,
      output ready,
      output dout_a, rvalid_a,
      output dout_b, rvalid_b
   );
endinterface

// File: rtl/ram_dp_bytemask_init.sv
// True dual-port RAM with lane write masks, 1/2-cycle read latency
// and a clear engine writing INIT_VALUE to every word after reset or clr.
// Ports: clock, reset_n (async, active low), bus (slave modport):
//   cen/clr/ready, and per port wen/lmask/addr/din -> dout/rvalid.
module ram_dp_bytemask_init #(
   parameter int                        DATA_WIDTH   = 32,
   parameter int                        LANE_WIDTH   = 8,
   parameter int                        DEPTH        = 16,
   parameter int                        READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0]     INIT_VALUE   = '0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   ram_dp_bytemask_init_if.slave  bus
);
   localparam int NL         = DATA_WIDTH / LANE_WIDTH;
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
      ADDR_WIDTH'(DEPTH - 1);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $fatal(1, "READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
      $fatal(1, "DATA_WIDTH must be a multiple of LANE_WIDTH");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "DEPTH must be at least 2");
   end

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   state_e                state_q;
   logic                  ready_q;
   logic [ADDR_WIDTH-1:0] caddr_q;

   // Clear engine: one word per cycle, then hand the array over.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_CLEAR;
         ready_q <= 1'b0;
         caddr_q <= '0;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               if (caddr_q == LAST_ADDR) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
                  caddr_q <= '0;
               end else begin
                  caddr_q <= caddr_q + ADDR_WIDTH'(1);
               end
            end
            ST_READY: begin
               if (bus.clr) begin
                  state_q <= ST_CLEAR;
                  ready_q <= 1'b0;
                  caddr_q <= '0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               ready_q <= 1'b0;
               caddr_q <= '0;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;

   logic acc;
   logic in_a;
   logic in_b;
   logic we_a;
   logic we_b;
   logic [1:0] re;

   assign acc  = bus.cen & ready_q;
   assign in_a = int'(bus.addr_a) < DEPTH;
   assign in_b = int'(bus.addr_b) < DEPTH;
   assign we_a = acc & bus.wen_a & in_a;
   assign we_b = acc & bus.wen_b & in_b;
   assign re   = {acc & ~bus.wen_b, acc & ~bus.wen_a};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Port B lanes are written first so that port A lanes, assigned
   // later in the same block, win on a same-address collision.
   always_ff @(posedge clock) begin
      if (state_q == ST_CLEAR) begin
         mem_q[caddr_q] <= INIT_VALUE;
      end else begin
         for (int i = 0; i < NL; i++) begin
            if (we_b && bus.lmask_b[i]) begin
               mem_q[bus.addr_b][i*LANE_WIDTH +: LANE_WIDTH] <=
                  bus.din_b[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
         for (int i = 0; i < NL; i++) begin
            if (we_a && bus.lmask_a[i]) begin
               mem_q[bus.addr_a][i*LANE_WIDTH +: LANE_WIDTH] <=
                  bus.din_a[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Read data is sampled before the edge, giving read-first
   // behaviour against a write from the other port.
   logic [DATA_WIDTH-1:0] rd_d [2];

   assign rd_d[0] = in_a ? mem_q[bus.addr_a] : '0;
   assign rd_d[1] = in_b ? mem_q[bus.addr_b] : '0;

   logic [1:0]            v1_q;
   logic [DATA_WIDTH-1:0] d1_q [2];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v1_q <= '0;
         for (int p = 0; p < 2; p++) begin
            d1_q[p] <= '0;
         end
      end else begin
         v1_q <= re;
         for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
               d1_q[p] <= rd_d[p];
            end
         end
      end
   end

   logic [1:0]            vo;
   logic [DATA_WIDTH-1:0] dout [2];

   if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]            v2_q;
      logic [DATA_WIDTH-1:0] d2_q [2];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            v2_q <= '0;
            for (int p = 0; p < 2; p++) begin
               d2_q[p] <= '0;
            end
         end else begin
            v2_q <= v1_q;
            for (int p = 0; p < 2; p++) begin
               if (v1_q[p]) begin
                  d2_q[p] <= d1_q[p];
               end
            end
         end
      end

      assign vo      = v2_q;
      assign dout[0] = d2_q[0];
      assign dout[1] = d2_q[1];
   end else begin : g_lat1
      assign vo      = v1_q;
      assign dout[0] = d1_q[0];
      assign dout[1] = d1_q[1];
   end

   assign bus.dout_a   = dout[0];
   assign bus.rvalid_a = vo[0];
   assign bus.dout_b   = dout[1];
   assign bus.rvalid_b = vo[1];
endmodule

// File: tb/tb_ram_dp_bytemask_init.sv
// Directed bench: DUT0 is DEPTH=16/latency 1/INIT 0,
// DUT1 is DEPTH=12/latency 2/INIT 0xA5A55A5A.
module tb_ram_dp_bytemask_init;
   localparam logic [31:0] I1 = 32'hA5A5_5A5A;

   typedef struct packed {
      logic        we;
      logic [3:0]  lm;
      logic [3:0]  ad;
      logic [31:0] di;
   } port_t;

   logic clock;
   logic reset_n;

   logic [1:0]  cen;
   logic [1:0]  clr;
   port_t       pa [2];
   port_t       pb [2];
   logic [1:0]  rdy;
   logic [1:0]  va;
   logic [1:0]  vb;
   logic [31:0] da [2];
   logic [31:0] db [2];

   int n_chk;
   int n_pass;

   ram_dp_bytemask_init_if #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(16)
   ) if0 ();
   ram_dp_bytemask_init_if #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(12)
   ) if1 ();

   ram_dp_bytemask_init #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(16),
      .READ_LATENCY(1), .INIT_VALUE(32'h0)
   ) u_dut0 (
      .clock(clock), .reset_n(reset_n), .bus(if0)
   );

   ram_dp_bytemask_init #(
      .DATA_WIDTH(32), .LANE_WIDTH(8), .DEPTH(12),
      .READ_LATENCY(2), .INIT_VALUE(I1)
   ) u_dut1 (
      .clock(clock), .reset_n(reset_n), .bus(if1)
   );

   assign if0.cen     = cen[0];
   assign if0.clr     = clr[0];
   assign if0.wen_a   = pa[0].we;
   assign if0.lmask_a = pa[0].lm;
   assign if0.addr_a  = pa[0].ad;
   assign if0.din_a   = pa[0].di;
   assign if0.wen_b   = pb[0].we;
   assign if0.lmask_b = pb[0].lm;
   assign if0.addr_b  = pb[0].ad;
   assign if0.din_b   = pb[0].di;
   assign rdy[0]      = if0.ready;
   assign va[0]       = if0.rvalid_a;
   assign vb[0]       = if0.rvalid_b;
   assign da[0]       = if0.dout_a;
   assign db[0]       = if0.dout_b;

   assign if1.cen     = cen[1];
   assign if1.clr     = clr[1];
   assign if1.wen_a   = pa[1].we;
   assign if1.lmask_a = pa[1].lm;
   assign if1.addr_a  = pa[1].ad;
   assign if1.din_a   = pa[1].di;
   assign if1.wen_b   = pb[1].we;
   assign if1.lmask_b = pb[1].lm;
   assign if1.addr_b  = pb[1].ad;
   assign if1.din_b   = pb[1].di;
   assign rdy[1]      = if1.ready;
   assign va[1]       = if1.rvalid_a;
   assign vb[1]       = if1.rvalid_b;
   assign da[1]       = if1.dout_a;
   assign db[1]       = if1.dout_b;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic port_t rd(input logic [3:0] a);
      return {1'b0, 4'h0, a, 32'h0};
   endfunction

   function automatic port_t wr(input logic [3:0] m,
                                input logic [3:0] a,
                                input logic [31:0] d);
      return {1'b1, m, a, d};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wait_ready(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int n = 1; n <= 40; n++) begin
         cyc();
         if (c0 == 0 && rdy[0]) c0 = n;
         if (c1 == 0 && rdy[1]) c1 = n;
         if (c0 != 0 && c1 != 0) break;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, cnt_a, cnt_b;
      logic any_v, expv;
      logic [31:0] ea, eb;
      n_chk   = 0;
      n_pass  = 0;
      reset_n = 1'b0;
      cen     = '0;
      clr     = '0;
      for (int p = 0; p < 2; p++) begin
         pa[p] = '0;
         pb[p] = '0;
      end
      cyc();
      cyc();
      chk("rst_ready0", rdy[0], 0);
      chk("rst_ready1", rdy[1], 0);
      chk("rst_rvalid0", va[0], 0);
      chk("rst_dout0", da[0], 0);
      reset_n = 1'b1;
      wait_ready(c0, c1);
      chk("clr_cycles0", c0, 16);
      chk("clr_cycles1", c1, 12);

      // all words start at INIT_VALUE
      cen[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pa[0] = rd(4'(i));
         pb[0] = rd(4'(15 - i));
         cyc();
         chk($sformatf("init_a%0d", i), da[0], 0);
         chk($sformatf("init_va%0d", i), va[0], 1);
         chk($sformatf("init_b%0d", 15 - i), db[0], 0);
      end

      // lane mask, and an all-zero mask as a no-op
      pa[0] = wr(4'b0101, 4'd3, 32'hAABB_CCDD);
      pb[0] = wr(4'b0000, 4'd3, 32'hFFFF_FFFF);
      cyc();
      chk("wr_no_rvalid", va[0], 0);
      pa[0] = rd(4'd3);
      pb[0] = rd(4'd3);
      cyc();
      chk("lane_mask", da[0], 32'h00BB_00DD);
      chk("mask0_noop", db[0], 32'h00BB_00DD);

      // write/write collision
      pa[0] = wr(4'b0011, 4'd5, 32'h1111_1111);
      pb[0] = wr(4'b0110, 4'd5, 32'h2222_2222);
      cyc();
      pa[0] = rd(4'd5);
      pb[0] = wr(4'h0, 4'd0, 32'h0);
      cyc();
      chk("ww_collide", da[0], 32'h0022_1111);

      // read-first across ports
      pa[0] = wr(4'hF, 4'd7, 32'h1234_5678);
      cyc();
      pa[0] = wr(4'hF, 4'd7, 32'hDEAD_BEEF);
      pb[0] = rd(4'd7);
      cyc();
      chk("rw_old_b", db[0], 32'h1234_5678);
      chk("rw_rvalid_b", vb[0], 1);
      chk("wr_hold_a", da[0], 32'h0022_1111);
      pa[0] = wr(4'h0, 4'd0, 32'h0);
      pb[0] = rd(4'd7);
      cyc();
      chk("rw_new_b", db[0], 32'hDEAD_BEEF);
      cen[0] = 1'b0;
      cyc();
      chk("idle_rvalid_b", vb[0], 0);
      chk("idle_hold_b", db[0], 32'hDEAD_BEEF);

      // clr together with a read
      cen[0] = 1'b1;
      pa[0]  = wr(4'hF, 4'd2, 32'h5);
      pb[0]  = wr(4'h0, 4'd0, 32'h0);
      cyc();
      pa[0]  = rd(4'd2);
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      chk("clr_read", da[0], 32'h5);
      chk("clr_rvalid", va[0], 1);
      chk("clr_ready_low", rdy[0], 0);

      // requests and a second clr during the clear are ignored
      pa[0] = wr(4'hF, 4'd0, 32'hFFFF_FFFF);
      pb[0] = rd(4'd1);
      any_v = 1'b0;
      c0    = 0;
      for (int n = 1; n <= 40; n++) begin
         clr[0] = (n == 5);
         cyc();
         if (va[0] || vb[0]) any_v = 1'b1;
         if (rdy[0]) begin
            c0 = n;
            break;
         end
      end
      clr[0] = 1'b0;
      cen[0] = 1'b0;
      chk("reclr_cycles", c0, 16);
      chk("clr_no_rvalid", any_v, 0);
      cen[0] = 1'b1;
      pa[0]  = rd(4'd0);
      pb[0]  = rd(4'd2);
      cyc();
      chk("reclr_a0", da[0], 0);
      chk("reclr_a2", db[0], 0);
      pa[0] = rd(4'd3);
      pb[0] = rd(4'd7);
      cyc();
      chk("reclr_a3", da[0], 0);
      chk("reclr_a7", db[0], 0);

      // reset in the middle of a clear
      pa[0] = wr(4'hF, 4'd9, 32'hCAFE_F00D);
      pb[0] = wr(4'h0, 4'd0, 32'h0);
      cyc();
      pa[0] = rd(4'd9);
      cyc();
      chk("pre_rst_a9", da[0], 32'hCAFE_F00D);
      cen[0] = 1'b0;
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      repeat (6) cyc();
      chk("mid_clr_busy", rdy[0], 0);
      reset_n = 1'b0;
      #1;
      chk("rst_dout_a", da[0], 0);
      chk("rst_ready", rdy[0], 0);
      cyc();
      reset_n = 1'b1;
      wait_ready(c0, c1);
      chk("rst_clr_cycles0", c0, 16);
      chk("rst_clr_cycles1", c1, 12);
      cen[0] = 1'b1;
      pa[0]  = rd(4'd9);
      pb[0]  = rd(4'd5);
      cyc();
      chk("post_rst_a9", da[0], 0);
      chk("post_rst_a5", db[0], 0);
      cen[0] = 1'b0;
      cyc();

      // DUT1: latency 2, non-zero INIT_VALUE
      cen[1] = 1'b1;
      pa[1]  = rd(4'd11);
      pb[1]  = wr(4'h0, 4'd0, 32'h0);
      cyc();
      chk("rl2_early", va[1], 0);
      cen[1] = 1'b0;
      cyc();
      chk("rl2_valid", va[1], 1);
      chk("rl2_init", da[1], I1);
      cyc();
      chk("rl2_one_pulse", va[1], 0);

      cen[1] = 1'b1;
      pa[1]  = wr(4'b0101, 4'd3, 32'hAABB_CCDD);
      cyc();
      pa[1] = rd(4'd3);
      cyc();
      cen[1] = 1'b0;
      cyc();
      chk("rl2_lane", da[1], 32'hA5BB_5ADD);

      // out-of-range write and read
      cen[1] = 1'b1;
      pa[1]  = wr(4'hF, 4'd13, 32'hFFFF_FFFF);
      cyc();
      pa[1] = rd(4'd13);
      cyc();
      cen[1] = 1'b0;
      cyc();
      chk("oor_dout", da[1], 0);
      chk("oor_rvalid", va[1], 1);

      // 10 back-to-back reads on both ports
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 14; k++) begin
         if (k < 10) begin
            cen[1] = 1'b1;
            pa[1]  = rd(4'(k));
            pb[1]  = rd(4'(11 - k));
         end else begin
            cen[1] = 1'b0;
         end
         cyc();
         expv = (k >= 1 && k <= 10);
         chk($sformatf("b2b_va%0d", k), va[1], expv);
         chk($sformatf("b2b_vb%0d", k), vb[1], expv);
         if (va[1]) cnt_a++;
         if (vb[1]) cnt_b++;
         if (expv) begin
            ea = (k - 1 == 3) ? 32'hA5BB_5ADD : I1;
            eb = (12 - k == 3) ? 32'hA5BB_5ADD : I1;
            chk($sformatf("b2b_da%0d", k), da[1], ea);
            chk($sformatf("b2b_db%0d", k), db[1], eb);
         end
      end
      chk("b2b_cnt_a", cnt_a, 10);
      chk("b2b_cnt_b", cnt_b, 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
